// File: rtl/uart_tx_feeder.sv
// FIFO-buffered feeder for the uart transmitter: issues one wr_en pulse per byte, paced on tx_busy.
// Define TX_AUTOCOUNT_EN to add a built-in incrementing-byte source for board bring-up.
module uart_tx_feeder #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 16,
  parameter int PERIOD       = 50000000
) (
  input  logic                   clk_50m,
  input  logic                   clear,
  input  logic [7:0]             wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_wr_en,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] T_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          push_req, push_ok, pop;
  logic [7:0]    push_data;

`ifdef TX_AUTOCOUNT_EN
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PERIOD - 1);

  logic [PW-1:0] interval;
  logic [7:0]    auto_byte;
  logic          auto_pending, auto_req, auto_try;

  // An auto request yields to wr_valid and is retried on the next free cycle.
  assign auto_req = (interval == P_LAST) || auto_pending;
  assign auto_try = auto_req && !wr_valid;

  always_ff @(posedge clk_50m or posedge clear) begin
    if (clear) begin
      interval     <= '0;
      auto_byte    <= 8'h00;
      auto_pending <= 1'b0;
    end else begin
      interval     <= (interval == P_LAST) ? '0 : interval + 1'b1;
      auto_pending <= auto_req && wr_valid;
      if (auto_try)
        auto_byte <= auto_byte + 8'd1;
    end
  end

  assign push_req  = wr_valid || auto_try;
  assign push_data = wr_valid ? wr_data : auto_byte;
`else
  assign push_req  = wr_valid;
  assign push_data = wr_data;
`endif

  assign wr_ready = (fifo_count != FULL);
  assign push_ok  = push_req && wr_ready;
  assign pop      = (state == IDLE) && (fifo_count != '0) && !tx_busy;

  always_ff @(posedge clk_50m or posedge clear) begin
    if (clear) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)
        fifo_count <= fifo_count + 1'b1;
      else if (pop && !push_ok)
        fifo_count <= fifo_count - 1'b1;
      if (push_req && !wr_ready)
        overflow <= 1'b1;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk_50m) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_50m or posedge clear) begin
    if (clear)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pop) state_next = ISSUE;
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)
          state_next = WAIT_DONE;
        else if (timer == T_LAST)
          state_next = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_wr_en = (state == ISSUE);
  end

  // A timed-out wait still counts the byte as sent; nothing is re-issued.
  always_ff @(posedge clk_50m or posedge clear) begin
    if (clear) begin
      timer   <= '0;
      tx_data <= 8'h00;
    end else begin
      timer <= (state == WAIT_BUSY && state_next == WAIT_BUSY) ? timer + 1'b1 : '0;
      if (pop)
        tx_data <= mem[rd_ptr];
    end
  end

endmodule
